// File: rtl/cam_capture.sv
// Camera-port capture front end: oversamples the OV7670-style parallel bus in the CLK domain,
// packs byte pairs into RGB332 pixels and issues frame-buffer write strobes.
module cam_capture #(
  parameter int unsigned SCREEN_WIDTH  = 176,
  parameter int unsigned SCREEN_HEIGHT = 144,
  parameter int unsigned ADDR_W        = 15,
  parameter int unsigned CNT_W         = 8
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              CAM_PCLK,
  input  logic              CAM_VSYNC,
  input  logic              CAM_HREF,
  input  logic [7:0]        CAM_DATA,
  input  logic [1:0]        FMT,
  input  logic              CONTINUOUS,
  input  logic              ARM,
  output logic [ADDR_W-1:0] W_ADDR,
  output logic [7:0]        W_DATA,
  output logic              W_EN,
  output logic              BUSY,
  output logic              FRAME_DONE,
  output logic [CNT_W-1:0]  FRAME_COUNT,
  output logic              CLIP_ERR,
  output logic              ODD_ERR
);

  localparam int unsigned XWidth = $clog2(SCREEN_WIDTH + 1);
  localparam int unsigned YWidth = $clog2(SCREEN_HEIGHT + 1);
  localparam logic [XWidth-1:0] XMax     = XWidth'(SCREEN_WIDTH);
  localparam logic [YWidth-1:0] YMax     = YWidth'(SCREEN_HEIGHT);
  localparam logic [ADDR_W-1:0] LineStep = ADDR_W'(SCREEN_WIDTH);

  typedef enum logic [1:0] {StIdle, StWaitStart, StActive} state_e;

  state_e state_q, state_d;

  logic [2:0] pclk_sync_q, vsync_sync_q, href_sync_q;
  logic [7:0] data_s1_q, data_s2_q;
  logic       pclk_rise, vs_rise, vs_fall, href_fall, href_s2;

  logic [XWidth-1:0] x_q, x_d;
  logic [YWidth-1:0] y_q, y_d;
  logic [ADDR_W-1:0] line_base_q, line_base_d;
  logic              phase_q, phase_d;
  logic [7:0]        b1_q, b1_d;
  logic [1:0]        fmt_q, fmt_d;

  logic [ADDR_W-1:0] w_addr_q, w_addr_d;
  logic [7:0]        w_data_q, w_data_d;
  logic              w_en_q, w_en_d;
  logic              busy_q;
  logic              frame_done_q, frame_done_d;
  logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic              clip_q, clip_d;
  logic              odd_q, odd_d;
  logic [7:0]        pixel;

  // Bit 1 is the settled (s2) sample, bit 2 the previous one (s3) for edge detection.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      pclk_sync_q  <= '0;
      vsync_sync_q <= '0;
      href_sync_q  <= '0;
      data_s1_q    <= '0;
      data_s2_q    <= '0;
    end else begin
      pclk_sync_q  <= {pclk_sync_q[1:0], CAM_PCLK};
      vsync_sync_q <= {vsync_sync_q[1:0], CAM_VSYNC};
      href_sync_q  <= {href_sync_q[1:0], CAM_HREF};
      data_s1_q    <= CAM_DATA;
      data_s2_q    <= data_s1_q;
    end
  end

  assign pclk_rise = pclk_sync_q[1] & ~pclk_sync_q[2];
  assign vs_rise   = vsync_sync_q[1] & ~vsync_sync_q[2];
  assign vs_fall   = ~vsync_sync_q[1] & vsync_sync_q[2];
  assign href_fall = ~href_sync_q[1] & href_sync_q[2];
  assign href_s2   = href_sync_q[1];

  // b1 is the first byte of the pair, data_s2_q the second.
  always_comb begin
    pixel = 8'h00;
    unique case (fmt_q)
      2'd0:    pixel = {b1_q[7:5], b1_q[2:0], data_s2_q[4:3]};
      2'd1:    pixel = {b1_q[3:1], data_s2_q[7:5], data_s2_q[3:2]};
      2'd2:    pixel = {b1_q[7:5], b1_q[7:5], b1_q[7:6]};
      default: pixel = 8'h00;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    line_base_d  = line_base_q;
    phase_d      = phase_q;
    b1_d         = b1_q;
    fmt_d        = fmt_q;
    w_addr_d     = w_addr_q;
    w_data_d     = w_data_q;
    w_en_d       = 1'b0;
    frame_done_d = 1'b0;
    frame_cnt_d  = frame_cnt_q;
    clip_d       = clip_q;
    odd_d        = odd_q;

    unique case (state_q)
      StIdle: begin
        if (ARM || CONTINUOUS) state_d = StWaitStart;
      end
      StWaitStart: begin
        if (vs_fall) begin
          state_d     = StActive;
          x_d         = '0;
          y_d         = '0;
          line_base_d = '0;
          phase_d     = 1'b0;
          clip_d      = 1'b0;
          odd_d       = 1'b0;
          fmt_d       = FMT;
        end
      end
      StActive: begin
        if (vs_rise) begin
          state_d      = CONTINUOUS ? StWaitStart : StIdle;
          frame_done_d = 1'b1;
          frame_cnt_d  = frame_cnt_q + 1'b1;
        end else if (href_fall) begin
          if (phase_q) odd_d = 1'b1;
          phase_d = 1'b0;
          x_d     = '0;
          if (y_q < YMax) begin
            y_d         = y_q + 1'b1;
            line_base_d = line_base_q + LineStep;
          end
        end else if (pclk_rise && href_s2) begin
          if (!phase_q) begin
            b1_d    = data_s2_q;
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            if (x_q < XMax && y_q < YMax) begin
              // Reserved format keeps counting geometry but never writes.
              if (fmt_q != 2'd3) begin
                w_en_d   = 1'b1;
                w_addr_d = line_base_q + ADDR_W'(x_q);
                w_data_d = pixel;
              end
            end else begin
              clip_d = 1'b1;
            end
            if (x_q != XMax) x_d = x_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= StIdle;
      x_q          <= '0;
      y_q          <= '0;
      line_base_q  <= '0;
      phase_q      <= 1'b0;
      b1_q         <= '0;
      fmt_q        <= '0;
      w_addr_q     <= '0;
      w_data_q     <= '0;
      w_en_q       <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
      clip_q       <= 1'b0;
      odd_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      line_base_q  <= line_base_d;
      phase_q      <= phase_d;
      b1_q         <= b1_d;
      fmt_q        <= fmt_d;
      w_addr_q     <= w_addr_d;
      w_data_q     <= w_data_d;
      w_en_q       <= w_en_d;
      busy_q       <= (state_q != StIdle);
      frame_done_q <= frame_done_d;
      frame_cnt_q  <= frame_cnt_d;
      clip_q       <= clip_d;
      odd_q        <= odd_d;
    end
  end

  assign W_ADDR      = w_addr_q;
  assign W_DATA      = w_data_q;
  assign W_EN        = w_en_q;
  assign BUSY        = busy_q;
  assign FRAME_DONE  = frame_done_q;
  assign FRAME_COUNT = frame_cnt_q;
  assign CLIP_ERR    = clip_q;
  assign ODD_ERR     = odd_q;

endmodule
